multi_timer_control: RTL and testbench

MULTI_TIMER_CONTROL -- requirements
Module: multi_timer_control

---
 rtl/mtc_pkg.sv | 34 +++
 rtl/mtc_channel.sv | 242 ++++++++++++++++++++++++
 rtl/multi_timer_control.sv | 94 +++++++++
 tb/tb_multi_timer_control.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mtc_pkg.sv
// ---------------------------------------------------------------------------
// mtc_pkg -- shared definitions for the multi-channel kitchen timer.
//   * mtc_state_e       : per-channel FSM state encoding
//   * SEC_MAX           : last value of the seconds field (59)
//   * AUTO_SILENCE_SECS : DONE dwell time when MTC_AUTO_SILENCE_EN is defined
//   * sec_inc_wrap()    : seconds increment that wraps 59 -> 0 without carry
// No ports (package).
// ---------------------------------------------------------------------------
package mtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROG  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } mtc_state_e;

  localparam logic [5:0] SEC_MAX           = 6'd59;
  localparam logic [5:0] AUTO_SILENCE_SECS = 6'd60;

  // Setting-mode seconds increment: wraps to zero and never touches minutes.
  function automatic logic [5:0] sec_inc_wrap(input logic [5:0] sec);
    logic [5:0] res;
    if (sec >= SEC_MAX) begin
      res = 6'd0;
    end else begin
      res = sec + 6'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mtc_channel.sv
// ---------------------------------------------------------------------------
// mtc_channel -- one timer channel: FSM, programmed setting and live count.
// Optional feature: define MTC_AUTO_SILENCE_EN to make DONE fall back to IDLE
// after AUTO_SILENCE_SECS seconds; otherwise DONE holds until a command.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   sec_tick        : once-per-second pulse (acts regardless of selection)
//   selected        : this channel is the one addressed by the user commands
//   cooktime_req    : level, program mode
//   start_timer, pause_req, clear_req, seconds_req, minutes_req : pulses
//   run, done       : channel is in RUN / DONE
//   disp_min/sec    : setting in IDLE/PROG, count in every other state
// ---------------------------------------------------------------------------
module mtc_channel
  import mtc_pkg::*;
#(
  parameter int MAX_MIN = 99,
  parameter int MIN_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sec_tick,
  input  logic             selected,
  input  logic             cooktime_req,
  input  logic             start_timer,
  input  logic             pause_req,
  input  logic             clear_req,
  input  logic             seconds_req,
  input  logic             minutes_req,
  output logic             run,
  output logic             done,
  output logic [MIN_W-1:0] disp_min,
  output logic [5:0]       disp_sec
);

  mtc_state_e       state_r, state_nxt_s;
  logic [MIN_W-1:0] set_min_r, set_min_nxt_s, cnt_min_r, cnt_min_nxt_s;
  logic [5:0]       set_sec_r, set_sec_nxt_s, cnt_sec_r, cnt_sec_nxt_s;
  logic             clr_s, cook_s, start_s, pause_s, inc_sec_s, inc_min_s;
  logic             set_nz_s, cnt_zero_s, silence_expire_s;

  // Minutes increment in program mode: wraps MAX_MIN -> 0.
  function automatic logic [MIN_W-1:0] min_inc_wrap(input logic [MIN_W-1:0] m);
    logic [MIN_W-1:0] res;
    if (m >= MIN_W'(MAX_MIN)) begin
      res = {MIN_W{1'b0}};
    end else begin
      res = m + MIN_W'(1);
    end
    return res;
  endfunction

  assign clr_s      = selected & clear_req;
  assign cook_s     = selected & cooktime_req;
  assign start_s    = selected & start_timer;
  assign pause_s    = selected & pause_req;
  assign inc_sec_s  = selected & seconds_req;
  assign inc_min_s  = selected & minutes_req;
  assign set_nz_s   = (set_min_r != {MIN_W{1'b0}}) || (set_sec_r != 6'd0);
  assign cnt_zero_s = (cnt_min_r == {MIN_W{1'b0}}) && (cnt_sec_r == 6'd0);

`ifdef MTC_AUTO_SILENCE_EN
  logic [5:0] silence_cnt_r;

  assign silence_expire_s = (state_r == ST_DONE) && sec_tick &&
                            (silence_cnt_r == (AUTO_SILENCE_SECS - 6'd1));

  // Counts seconds spent in DONE; cleared whenever the channel is elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      silence_cnt_r <= 6'd0;
    end else if (state_r != ST_DONE) begin
      silence_cnt_r <= 6'd0;
    end else if (sec_tick) begin
      silence_cnt_r <= silence_cnt_r + 6'd1;
    end else begin
      silence_cnt_r <= silence_cnt_r;
    end
  end
`else
  assign silence_expire_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear beats everything, then cooktime, start, pause.
  always_comb begin
    state_nxt_s = state_r;
    if (clr_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_PROG: begin
          if (cook_s) begin
            state_nxt_s = ST_PROG;
          end else if (start_s && set_nz_s) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_LOAD: state_nxt_s = ST_RUN;
        ST_RUN: begin
          // Reaching 00:00 is seen one edge after the final tick.
          if (cook_s) begin
            state_nxt_s = ST_PROG;
          end else if (pause_s) begin
            state_nxt_s = ST_PAUSE;
          end else if (cnt_zero_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (cook_s) begin
            state_nxt_s = ST_PROG;
          end else if (start_s) begin
            state_nxt_s = ST_LOAD;
          end else if (pause_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (cook_s) begin
            state_nxt_s = ST_PROG;
          end else if (start_s) begin
            state_nxt_s = ST_LOAD;
          end else if (silence_expire_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Setting/count next values; a command in RUN suppresses that cycle's tick.
  always_comb begin
    set_min_nxt_s = set_min_r;
    set_sec_nxt_s = set_sec_r;
    cnt_min_nxt_s = cnt_min_r;
    cnt_sec_nxt_s = cnt_sec_r;
    if (clr_s) begin
      cnt_min_nxt_s = {MIN_W{1'b0}};
      cnt_sec_nxt_s = 6'd0;
    end else begin
      case (state_r)
        ST_PROG: begin
          if (cook_s && inc_sec_s) begin
            set_sec_nxt_s = sec_inc_wrap(set_sec_r);
          end else begin
            set_sec_nxt_s = set_sec_r;
          end
          if (cook_s && inc_min_s) begin
            set_min_nxt_s = min_inc_wrap(set_min_r);
          end else begin
            set_min_nxt_s = set_min_r;
          end
        end
        ST_LOAD: begin
          cnt_min_nxt_s = set_min_r;
          cnt_sec_nxt_s = set_sec_r;
        end
        ST_RUN: begin
          if (cook_s) begin
            cnt_min_nxt_s = {MIN_W{1'b0}};
            cnt_sec_nxt_s = 6'd0;
          end else if (pause_s || !sec_tick || cnt_zero_s) begin
            cnt_min_nxt_s = cnt_min_r;
            cnt_sec_nxt_s = cnt_sec_r;
          end else if (cnt_sec_r != 6'd0) begin
            cnt_sec_nxt_s = cnt_sec_r - 6'd1;
          end else begin
            cnt_min_nxt_s = cnt_min_r - MIN_W'(1);
            cnt_sec_nxt_s = SEC_MAX;
          end
        end
        ST_PAUSE, ST_DONE: begin
          if (cook_s) begin
            cnt_min_nxt_s = {MIN_W{1'b0}};
            cnt_sec_nxt_s = 6'd0;
          end else begin
            cnt_min_nxt_s = cnt_min_r;
            cnt_sec_nxt_s = cnt_sec_r;
          end
        end
        default: begin
          cnt_min_nxt_s = cnt_min_r;
          cnt_sec_nxt_s = cnt_sec_r;
        end
      endcase
    end
  end

  // Setting and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_min_r <= {MIN_W{1'b0}};
      set_sec_r <= 6'd0;
      cnt_min_r <= {MIN_W{1'b0}};
      cnt_sec_r <= 6'd0;
    end else begin
      set_min_r <= set_min_nxt_s;
      set_sec_r <= set_sec_nxt_s;
      cnt_min_r <= cnt_min_nxt_s;
      cnt_sec_r <= cnt_sec_nxt_s;
    end
  end

  // Output decode from the state register.
  always_comb begin
    run      = 1'b0;
    done     = 1'b0;
    disp_min = cnt_min_r;
    disp_sec = cnt_sec_r;
    case (state_r)
      ST_IDLE, ST_PROG: begin
        disp_min = set_min_r;
        disp_sec = set_sec_r;
      end
      ST_RUN:  run  = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        run  = 1'b0;
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_timer_control.sv
// ---------------------------------------------------------------------------
// multi_timer_control -- NUM_CH independent countdown timers sharing one user
// interface (sel addresses the channel) and one LED flash register.
// Optional feature macro: MTC_AUTO_SILENCE_EN (DONE auto-returns to IDLE).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   sec_tick, led_pulse : 1 Hz tick and LED flash-rate pulse
//   sel                 : addressed channel
//   cooktime_req (level), start_timer, pause_req, clear_req,
//   seconds_req, minutes_req (pulses) : user commands
//   run_led[i]          : channel i running
//   alert_led[i]        : channel i done, gated by the flash phase
//   alarm               : any channel done
//   disp_min, disp_sec  : time shown for the selected channel
// ---------------------------------------------------------------------------
module multi_timer_control
  import mtc_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int MAX_MIN = 99,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MIN_W   = $clog2(MAX_MIN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_tick,
  input  logic              led_pulse,
  input  logic [CH_W-1:0]   sel,
  input  logic              cooktime_req,
  input  logic              start_timer,
  input  logic              pause_req,
  input  logic              clear_req,
  input  logic              seconds_req,
  input  logic              minutes_req,
  output logic [NUM_CH-1:0] run_led,
  output logic [NUM_CH-1:0] alert_led,
  output logic              alarm,
  output logic [MIN_W-1:0]  disp_min,
  output logic [5:0]        disp_sec
);

  logic             flash_r;
  logic [NUM_CH-1:0] done_s;
  logic [MIN_W-1:0] ch_min_s [NUM_CH];
  logic [5:0]       ch_sec_s [NUM_CH];

  // Shared flash phase for all alert LEDs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_r <= 1'b0;
    end else if (led_pulse) begin
      flash_r <= ~flash_r;
    end else begin
      flash_r <= flash_r;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mtc_channel #(
      .MAX_MIN (MAX_MIN),
      .MIN_W   (MIN_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .sec_tick     (sec_tick),
      .selected     (sel == CH_W'(i)),
      .cooktime_req (cooktime_req),
      .start_timer  (start_timer),
      .pause_req    (pause_req),
      .clear_req    (clear_req),
      .seconds_req  (seconds_req),
      .minutes_req  (minutes_req),
      .run          (run_led[i]),
      .done         (done_s[i]),
      .disp_min     (ch_min_s[i]),
      .disp_sec     (ch_sec_s[i])
    );
  end

  assign alert_led = done_s & {NUM_CH{flash_r}};
  assign alarm     = |done_s;

  // Display mux; a sel value with no channel behind it shows 00:00.
  always_comb begin
    if (int'(sel) < NUM_CH) begin
      disp_min = ch_min_s[sel];
      disp_sec = ch_sec_s[sel];
    end else begin
      disp_min = {MIN_W{1'b0}};
      disp_sec = 6'd0;
    end
  end

endmodule

// File: tb/tb_multi_timer_control.sv
module tb_multi_timer_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tick = 1'b0, led_pulse = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cooktime_req = 1'b0, start_timer = 1'b0, pause_req = 1'b0;
  logic       clear_req = 1'b0, seconds_req = 1'b0, minutes_req = 1'b0;
  logic [3:0] run_led, alert_led;
  logic       alarm;
  logic [6:0] disp_min;
  logic [5:0] disp_sec;

  int checks = 0;
  int errors = 0;

  multi_timer_control #(.NUM_CH(4), .MAX_MIN(99)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .led_pulse(led_pulse),
    .sel(sel), .cooktime_req(cooktime_req), .start_timer(start_timer),
    .pause_req(pause_req), .clear_req(clear_req), .seconds_req(seconds_req),
    .minutes_req(minutes_req), .run_led(run_led), .alert_led(alert_led),
    .alarm(alarm), .disp_min(disp_min), .disp_sec(disp_sec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int m, input int s);
    check(tag, {19'd0, disp_min, disp_sec}, {19'd0, 7'(m), 6'(s)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sec_tick = 1'b1;
      step();
    end
    sec_tick = 1'b0;
  endtask

  // Enter PROG on channel ch, add m minutes and s seconds, drop cooktime.
  task automatic prog(input logic [1:0] ch, input int m, input int s);
    sel = ch;
    cooktime_req = 1'b1;
    step();
    repeat (m) begin minutes_req = 1'b1; step(); end
    minutes_req = 1'b0;
    repeat (s) begin seconds_req = 1'b1; step(); end
    seconds_req = 1'b0;
    cooktime_req = 1'b0;
    step();
  endtask

  task automatic start_cmd();
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_run"}, {28'd0, run_led}, 32'd0);
    check({tag, "_alert"}, {28'd0, alert_led}, 32'd0);
    check({tag, "_alarm"}, {31'd0, alarm}, 32'd0);
    check_disp({tag, "_disp"}, 0, 0);
  endtask

  initial begin
    // Reset
    #2 reset = 1'b1;
    step(); step();
    check_all_zero("in_reset");
    reset = 1'b0;
    step();
    check_all_zero("after_reset");

    // Start on a 00:00 setting is ignored
    sel = 2'd0;
    start_cmd();
    step();
    check("start_zero_run", {28'd0, run_led}, 32'd0);
    check_disp("start_zero_disp", 0, 0);

    // Program-mode wraps on ch3
    prog(2'd3, 3, 59);
    check_disp("prog_03_59", 3, 59);
    cooktime_req = 1'b1;
    seconds_req = 1'b1; step(); seconds_req = 1'b0;
    check_disp("sec_wrap", 3, 0);
    repeat (96) begin minutes_req = 1'b1; step(); end
    minutes_req = 1'b0;
    check_disp("min_99", 99, 0);
    minutes_req = 1'b1; step(); minutes_req = 1'b0;
    check_disp("min_wrap", 0, 0);
    // clear outranks cooktime in the same cycle
    clear_req = 1'b1; step(); clear_req = 1'b0; cooktime_req = 1'b0;
    seconds_req = 1'b1; step(); seconds_req = 1'b0;
    check_disp("clear_over_cook", 0, 0);

    // ch2 at 01:05: LOAD one cycle, RUN, DONE after 65 ticks
    prog(2'd2, 1, 5);
    check_disp("ch2_setting", 1, 5);
    start_cmd();
    check("load_run", {28'd0, run_led}, 32'd0);
    check_disp("load_disp", 0, 0);
    step();
    check("run_led_ch2", {28'd0, run_led}, 32'd4);
    check_disp("run_disp", 1, 5);
    ticks(64);
    check_disp("ch2_00_01", 0, 1);
    ticks(1);
    check_disp("ch2_00_00", 0, 0);
    step();
    check("done_run", {28'd0, run_led}, 32'd0);
    check("done_alarm", {31'd0, alarm}, 32'd1);
    check("alert_flash0", {28'd0, alert_led}, 32'd0);
    led_pulse = 1'b1; step(); led_pulse = 1'b0;
    check("alert_flash1", {28'd0, alert_led}, 32'd4);
    led_pulse = 1'b1; step(); led_pulse = 1'b0;
    check("alert_flash2", {28'd0, alert_led}, 32'd0);
    ticks(59);
    check("done_59", {31'd0, alarm}, 32'd1);
    ticks(1);
`ifdef MTC_AUTO_SILENCE_EN
    check("done_60", {31'd0, alarm}, 32'd0);
    ticks(5);
    check("done_65", {31'd0, alarm}, 32'd0);
`else
    check("done_60", {31'd0, alarm}, 32'd1);
    ticks(5);
    check("done_65", {31'd0, alarm}, 32'd1);
`endif
    clear_req = 1'b1; step(); clear_req = 1'b0;
    check("clear_alarm", {31'd0, alarm}, 32'd0);
    check_disp("clear_keeps_set", 1, 5);

    // Concurrent channels: ch0 02:00, ch1 00:03
    prog(2'd0, 2, 0);
    start_cmd(); step();
    prog(2'd1, 0, 3);
    start_cmd(); step();
    check("two_run", {28'd0, run_led}, 32'd3);
    ticks(3);
    step();
    check("ch1_done_run", {28'd0, run_led}, 32'd1);
    check("ch1_alarm", {31'd0, alarm}, 32'd1);
    check_disp("ch1_disp", 0, 0);
    sel = 2'd0; #1;
    check_disp("ch0_01_57", 1, 57);

    // Pause coinciding with tick on ch1 at 00:10
    prog(2'd1, 0, 7);
    check_disp("ch1_00_10", 0, 10);
    check("reprog_alarm", {31'd0, alarm}, 32'd0);
    start_cmd(); step();
    check("ch1_rerun", {28'd0, run_led}, 32'd3);
    pause_req = 1'b1; sec_tick = 1'b1; step();
    pause_req = 1'b0; sec_tick = 1'b0;
    check("pause_led", {28'd0, run_led}, 32'd1);
    check_disp("pause_disp", 0, 10);
    ticks(5);
    check_disp("paused_5", 0, 10);
    pause_req = 1'b1; step(); pause_req = 1'b0;
    check("resume_led", {28'd0, run_led}, 32'd3);
    check_disp("resume_disp", 0, 10);
    ticks(1);
    check_disp("resume_tick", 0, 9);
    sel = 2'd0; #1;
    check_disp("ch0_01_50", 1, 50);

    // Asynchronous reset mid-RUN
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    reset = 1'b0;
    step();
    sel = 2'd0;
    start_cmd(); step();
    check("post_reset_start", {28'd0, run_led}, 32'd0);
    check_disp("post_reset_disp", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
